// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and pipeline-bubble defaults for the decode stage.
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  // RNONE at the default 4-bit register index width; the stage derives its own all-ones value.
  localparam logic [3:0] RNONE        = 4'hF;
  localparam logic [3:0] BUBBLE_ICODE = 4'h1;
  localparam logic [3:0] BUBBLE_IFUN  = 4'h0;

endpackage

// File: rtl/decode_stage_p_fwd_mux.sv
// Operand forwarding for one source index: picks the youngest in-flight producer.
module decode_fwd_mux #(
  parameter int DATA_W = 64,
  parameter int RA_W   = 4
) (
  input  logic [RA_W-1:0]   src,
  input  logic [RA_W-1:0]   e_dstE,
  input  logic [RA_W-1:0]   M_dstM,
  input  logic [RA_W-1:0]   M_dstE,
  input  logic [RA_W-1:0]   W_dstM,
  input  logic [RA_W-1:0]   W_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] W_valM,
  input  logic [DATA_W-1:0] W_valE,
  output logic [DATA_W-1:0] val,
  output logic              hit
);
  localparam logic [RA_W-1:0] RNONE_R = '1;

  always_comb begin
    val = '0;
    hit = 1'b1;
    if (src == RNONE_R)      hit = 1'b0;
    else if (src == e_dstE)  val = e_valE;
    else if (src == M_dstM)  val = m_valM;
    else if (src == M_dstE)  val = M_valE;
    else if (src == W_dstM)  val = W_valM;
    else if (src == W_dstE)  val = W_valE;
    else                     hit = 1'b0;
  end
endmodule

// File: rtl/decode_stage_p.sv
// Y86-64 decode stage: F/D register, register selection, hazard control, D/E register.
// `define DECODE_FWD_EN to enable forwarding (otherwise any in-flight producer stalls).
module decode_stage_p
  import y86_pkg::*;
#(
  parameter int          DATA_W = 64,
  parameter int          RA_W   = 4,
  parameter int unsigned RSP_ID = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_valid,
  input  logic [3:0]        f_icode,
  input  logic [3:0]        f_ifun,
  input  logic [RA_W-1:0]   f_rA,
  input  logic [RA_W-1:0]   f_rB,
  input  logic [DATA_W-1:0] f_valC,
  input  logic [DATA_W-1:0] f_valP,
  input  logic              d_stall_ext,
  input  logic              flush,
  output logic              d_ready,
  output logic [RA_W-1:0]   rf_srcA,
  output logic [RA_W-1:0]   rf_srcB,
  input  logic [DATA_W-1:0] rf_valA,
  input  logic [DATA_W-1:0] rf_valB,
  input  logic [RA_W-1:0]   e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [RA_W-1:0]   M_dstE,
  input  logic [RA_W-1:0]   M_dstM,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [RA_W-1:0]   W_dstE,
  input  logic [RA_W-1:0]   W_dstM,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [DATA_W-1:0] W_valM,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [RA_W-1:0]   E_dstE,
  output logic [RA_W-1:0]   E_dstM,
  output logic [RA_W-1:0]   E_srcA,
  output logic [RA_W-1:0]   E_srcB,
  output logic              E_valid
);
  localparam logic [RA_W-1:0] RNONE_R = '1;
  localparam logic [RA_W-1:0] RSP     = RA_W'(RSP_ID);

  logic [3:0]        d_icode, d_ifun;
  logic [RA_W-1:0]   d_rA, d_rB;
  logic [DATA_W-1:0] d_valC, d_valP;
  logic              d_valid;

  logic [RA_W-1:0]   d_srcA, d_srcB, d_dstE, d_dstM;
  logic [DATA_W-1:0] sel_a, sel_b, d_valA;
  logic              hazard, hold;

  always_comb begin
    d_srcA = RNONE_R;
    d_srcB = RNONE_R;
    d_dstE = RNONE_R;
    d_dstM = RNONE_R;
    case (d_icode)
      I_RRMOVQ: begin d_srcA = d_rA; d_dstE = d_rB; end
      I_IRMOVQ: d_dstE = d_rB;
      I_RMMOVQ: begin d_srcA = d_rA; d_srcB = d_rB; end
      I_MRMOVQ: begin d_srcB = d_rB; d_dstM = d_rA; end
      I_OPQ:    begin d_srcA = d_rA; d_srcB = d_rB; d_dstE = d_rB; end
      I_CALL:   begin d_srcB = RSP; d_dstE = RSP; end
      I_RET:    begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; end
      I_PUSHQ:  begin d_srcA = d_rA; d_srcB = RSP; d_dstE = RSP; end
      I_POPQ:   begin d_srcA = RSP; d_srcB = RSP; d_dstE = RSP; d_dstM = d_rA; end
      default:  ;
    endcase
  end

`ifdef DECODE_FWD_EN
  logic [DATA_W-1:0] fwd_a, fwd_b;
  logic              hit_a, hit_b;

  decode_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_a (
    .src(d_srcA), .e_dstE(e_dstE), .M_dstM(M_dstM), .M_dstE(M_dstE),
    .W_dstM(W_dstM), .W_dstE(W_dstE), .e_valE(e_valE), .m_valM(m_valM),
    .M_valE(M_valE), .W_valM(W_valM), .W_valE(W_valE), .val(fwd_a), .hit(hit_a)
  );
  decode_fwd_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_fwd_b (
    .src(d_srcB), .e_dstE(e_dstE), .M_dstM(M_dstM), .M_dstE(M_dstE),
    .W_dstM(W_dstM), .W_dstE(W_dstE), .e_valE(e_valE), .m_valM(m_valM),
    .M_valE(M_valE), .W_valM(W_valM), .W_valE(W_valE), .val(fwd_b), .hit(hit_b)
  );

  // Only a load in execute cannot be forwarded in time.
  assign hazard = (E_dstM != RNONE_R) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign sel_a  = hit_a ? fwd_a : rf_valA;
  assign sel_b  = hit_b ? fwd_b : rf_valB;
`else
  logic [6*RA_W-1:0] busy;
  logic              unused_fwd;

  assign busy       = {E_dstE, E_dstM, M_dstE, M_dstM, W_dstE, W_dstM};
  assign unused_fwd = ^{e_dstE, e_valE, M_valE, m_valM, W_valE, W_valM};

  // Without forwarding, wait until every in-flight writer of a source has retired.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if ((d_srcA != RNONE_R && d_srcA == busy[i*RA_W +: RA_W]) ||
          (d_srcB != RNONE_R && d_srcB == busy[i*RA_W +: RA_W]))
        hazard = 1'b1;
    end
  end

  assign sel_a = rf_valA;
  assign sel_b = rf_valB;
`endif

  assign d_valA  = (d_icode == I_JXX || d_icode == I_CALL) ? d_valP : sel_a;
  assign hold    = hazard | d_stall_ext;
  assign d_ready = flush | ~hold;
  assign rf_srcA = d_srcA;
  assign rf_srcB = d_srcB;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush || (!hold && !f_valid)) begin
      if (!rst_n || flush || !hold) begin
        d_icode <= BUBBLE_ICODE;
        d_ifun  <= BUBBLE_IFUN;
        d_rA    <= RNONE_R;
        d_rB    <= RNONE_R;
        d_valC  <= '0;
        d_valP  <= '0;
        d_valid <= 1'b0;
      end
    end else if (!hold) begin
      d_icode <= f_icode;
      d_ifun  <= f_ifun;
      d_rA    <= f_rA;
      d_rB    <= f_rB;
      d_valC  <= f_valC;
      d_valP  <= f_valP;
      d_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      E_icode <= BUBBLE_ICODE;
      E_ifun  <= BUBBLE_IFUN;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RNONE_R;
      E_dstM  <= RNONE_R;
      E_srcA  <= RNONE_R;
      E_srcB  <= RNONE_R;
      E_valid <= 1'b0;
    end else if (flush || hold || !d_valid) begin
      E_icode <= BUBBLE_ICODE;
      E_ifun  <= BUBBLE_IFUN;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RNONE_R;
      E_dstM  <= RNONE_R;
      E_srcA  <= RNONE_R;
      E_srcB  <= RNONE_R;
      E_valid <= 1'b0;
    end else begin
      E_icode <= d_icode;
      E_ifun  <= d_ifun;
      E_valC  <= d_valC;
      E_valA  <= d_valA;
      E_valB  <= sel_b;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
      E_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: instruction-level model checked every cycle, plus directed scenarios.
module tb_decode_stage_p;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_valid;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic        d_stall_ext, flush, d_ready;
  logic [3:0]  rf_srcA, rf_srcB;
  logic [63:0] rf_valA, rf_valB;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
  logic        E_valid;

  logic [63:0] rf [16];
  assign rf_valA = rf[rf_srcA];
  assign rf_valB = rf[rf_srcB];

  decode_stage_p dut (
    .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_icode(f_icode), .f_ifun(f_ifun),
    .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
    .d_stall_ext(d_stall_ext), .flush(flush), .d_ready(d_ready),
    .rf_srcA(rf_srcA), .rf_srcB(rf_srcB), .rf_valA(rf_valA), .rf_valB(rf_valB),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .M_valE(M_valE), .m_valM(m_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE),
    .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB), .E_valid(E_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  typedef struct packed {
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        valid;
  } fd_t;

  typedef struct packed {
    logic [3:0]  icode, ifun;
    logic [63:0] valC, valA, valB;
    logic [3:0]  dstE, dstM, srcA, srcB;
    logic        valid;
  } de_t;

  fd_t m_fd;
  de_t m_de;

  function automatic fd_t fd_bubble();
    fd_t b;
    b = '{icode: 4'h1, ifun: 4'h0, rA: 4'hF, rB: 4'hF, valC: 64'h0, valP: 64'h0, valid: 1'b0};
    return b;
  endfunction

  function automatic de_t de_bubble();
    de_t b;
    b = '{icode: 4'h1, ifun: 4'h0, valC: 64'h0, valA: 64'h0, valB: 64'h0,
          dstE: 4'hF, dstM: 4'hF, srcA: 4'hF, srcB: 4'hF, valid: 1'b0};
    return b;
  endfunction

  // Register roles per instruction class, straight from the ISA table.
  function automatic logic [3:0] m_srcA(input fd_t x);
    if (x.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) return x.rA;
    if (x.icode inside {4'h9, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_srcB(input fd_t x);
    if (x.icode inside {4'h4, 4'h5, 4'h6}) return x.rB;
    if (x.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstE(input fd_t x);
    if (x.icode inside {4'h2, 4'h3, 4'h6}) return x.rB;
    if (x.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [63:0] m_operand(input logic [3:0] s);
`ifdef DECODE_FWD_EN
    logic [3:0]  d [5];
    logic [63:0] v [5];
    d = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    v = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (s != 4'hF)
      for (int i = 0; i < 5; i++)
        if (d[i] == s) return v[i];
`endif
    return rf[s];
  endfunction

  function automatic logic m_hazard(input logic [3:0] sa, input logic [3:0] sb);
`ifdef DECODE_FWD_EN
    return (m_de.dstM != 4'hF) && (m_de.dstM == sa || m_de.dstM == sb);
`else
    logic [3:0] d [6];
    d = '{m_de.dstE, m_de.dstM, M_dstE, M_dstM, W_dstE, W_dstM};
    for (int i = 0; i < 6; i++)
      if ((sa != 4'hF && sa == d[i]) || (sb != 4'hF && sb == d[i])) return 1'b1;
    return 1'b0;
`endif
  endfunction

  function automatic de_t m_decode(input fd_t x);
    de_t r;
    if (!x.valid) return de_bubble();
    r.icode = x.icode;
    r.ifun  = x.ifun;
    r.valC  = x.valC;
    r.srcA  = m_srcA(x);
    r.srcB  = m_srcB(x);
    r.dstE  = m_dstE(x);
    r.dstM  = (x.icode inside {4'h5, 4'hB}) ? x.rA : 4'hF;
    r.valA  = (x.icode inside {4'h7, 4'h8}) ? x.valP : m_operand(r.srcA);
    r.valB  = m_operand(r.srcB);
    r.valid = 1'b1;
    return r;
  endfunction

  // Compare process: inputs settle right after the falling edge, registers after the rising edge.
  logic [3:0] c_sa, c_sb;
  logic       c_hold;
  fd_t        c_fetch;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      m_fd = fd_bubble();
      m_de = de_bubble();
    end
    c_sa   = m_srcA(m_fd);
    c_sb   = m_srcB(m_fd);
    c_hold = m_hazard(c_sa, c_sb) || d_stall_ext;
    chk("rf_srcA", rf_srcA, c_sa);
    chk("rf_srcB", rf_srcB, c_sb);
    chk("d_ready", d_ready, flush || !c_hold);
    chk("E_icode", E_icode, m_de.icode);
    chk("E_ifun",  E_ifun,  m_de.ifun);
    chk("E_valC",  E_valC,  m_de.valC);
    chk("E_valA",  E_valA,  m_de.valA);
    chk("E_valB",  E_valB,  m_de.valB);
    chk("E_dstE",  E_dstE,  m_de.dstE);
    chk("E_dstM",  E_dstM,  m_de.dstM);
    chk("E_srcA",  E_srcA,  m_de.srcA);
    chk("E_srcB",  E_srcB,  m_de.srcB);
    chk("E_valid", E_valid, m_de.valid);
    if (rst_n) begin
      if (flush) begin
        m_fd = fd_bubble();
        m_de = de_bubble();
      end else if (c_hold) begin
        m_de = de_bubble();
      end else begin
        m_de = m_decode(m_fd);
        c_fetch = '{icode: f_icode, ifun: f_ifun, rA: f_rA, rB: f_rB,
                    valC: f_valC, valP: f_valP, valid: 1'b1};
        m_fd = f_valid ? c_fetch : fd_bubble();
      end
    end
  end

  task automatic idle();
    f_valid = 1'b0; f_icode = 4'h1; f_ifun = 4'h0; f_rA = 4'hF; f_rB = 4'hF;
    f_valC = '0; f_valP = '0; d_stall_ext = 1'b0; flush = 1'b0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp);
    f_valid = 1'b1; f_icode = ic; f_ifun = fn; f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
  endtask

  task automatic drain();
    repeat (2) begin @(negedge clk); idle(); end
  endtask

  function automatic logic [3:0] rdst();
    if ($urandom_range(0, 3) != 0) return 4'hF;
    return 4'($urandom_range(0, 14));
  endfunction

  initial begin
    idle();
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = 64'h1000 + 64'(i);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("rst_E_icode", E_icode, 64'h1);
    chk("rst_E_valid", E_valid, 64'h0);
    chk("rst_E_dstE", E_dstE, 64'hF);
    chk("rst_d_ready", d_ready, 64'h1);

    // irmovq $5,%rax
    @(negedge clk); idle(); fetch(4'h3, 4'h0, 4'hF, 4'h0, 64'd5, 64'h10A);
    @(negedge clk); idle();
    @(negedge clk); idle(); #3;
    chk("irm_icode", E_icode, 64'h3);
    chk("irm_valC", E_valC, 64'd5);
    chk("irm_dstE", E_dstE, 64'h0);
    chk("irm_srcA", E_srcA, 64'hF);
    chk("irm_valid", E_valid, 64'h1);
    drain();

    // addq %rbx,%rcx with a producer in execute
    @(negedge clk); idle(); rf[3] = 64'h99; rf[1] = 64'h2; fetch(4'h6, 4'h0, 4'h3, 4'h1, 64'h0, 64'h0);
    @(negedge clk); idle(); e_dstE = 4'h3; e_valE = 64'h11;
`ifdef DECODE_FWD_EN
    M_dstM = 4'h3; m_valM = 64'h77;
`endif
    @(negedge clk); idle(); #3;
    chk("addq_icode", E_icode, 64'h6);
`ifdef DECODE_FWD_EN
    chk("addq_fwd_valA", E_valA, 64'h11);
`else
    chk("addq_rf_valA", E_valA, 64'h99);
`endif
    chk("addq_valB", E_valB, 64'h2);
    drain();

`ifdef DECODE_FWD_EN
    // mrmovq 0(%rdx),%rax ; addq %rax,%rbx
    @(negedge clk); idle(); fetch(4'h5, 4'h0, 4'h0, 4'h2, 64'h0, 64'h0);
    @(negedge clk); idle(); fetch(4'h6, 4'h0, 4'h0, 4'h3, 64'h0, 64'h0);
    @(negedge clk); idle(); #3;
    chk("lu_ready_low", d_ready, 64'h0);
    @(negedge clk); idle(); M_dstM = 4'h0; m_valM = 64'h55; #3;
    chk("lu_bubble_valid", E_valid, 64'h0);
    chk("lu_bubble_icode", E_icode, 64'h1);
    chk("lu_hold_srcA", rf_srcA, 64'h0);
    chk("lu_ready_back", d_ready, 64'h1);
    @(negedge clk); idle(); #3;
    chk("lu_issue_icode", E_icode, 64'h6);
    chk("lu_issue_valA", E_valA, 64'h55);
    drain();
`else
    // rrmovq %rax,%rbx ; addq %rbx,%rcx, with the producer walking through M and W
    @(negedge clk); idle(); fetch(4'h2, 4'h0, 4'h0, 4'h3, 64'h0, 64'h0);
    @(negedge clk); idle(); fetch(4'h6, 4'h0, 4'h3, 4'h1, 64'h0, 64'h0);
    @(negedge clk); idle(); #3;
    chk("nf_stall_E", d_ready, 64'h0);
    @(negedge clk); idle(); M_dstE = 4'h3; #3;
    chk("nf_stall_M", d_ready, 64'h0);
    chk("nf_bubble", E_valid, 64'h0);
    @(negedge clk); idle(); W_dstE = 4'h3; #3;
    chk("nf_stall_W", d_ready, 64'h0);
    @(negedge clk); idle(); rf[3] = 64'hAB; #3;
    chk("nf_release", d_ready, 64'h1);
    @(negedge clk); idle(); #3;
    chk("nf_issue_icode", E_icode, 64'h6);
    chk("nf_issue_valA", E_valA, 64'hAB);
    drain();
`endif

    // call with valP=0x40
    @(negedge clk); idle(); fetch(4'h8, 4'h0, 4'hF, 4'hF, 64'h0, 64'h40);
    @(negedge clk); idle();
    @(negedge clk); idle(); #3;
    chk("call_valA", E_valA, 64'h40);
    chk("call_srcB", E_srcB, 64'h4);
    chk("call_dstE", E_dstE, 64'h4);
    drain();

    // flush during a load-use stall
    @(negedge clk); idle(); fetch(4'h5, 4'h0, 4'h0, 4'h2, 64'h0, 64'h0);
    @(negedge clk); idle(); fetch(4'h6, 4'h0, 4'h0, 4'h3, 64'h0, 64'h0);
    @(negedge clk); idle(); flush = 1'b1;
    @(negedge clk); idle(); #3;
    chk("fl_E_valid", E_valid, 64'h0);
    chk("fl_fd_srcA", rf_srcA, 64'hF);
    chk("fl_ready", d_ready, 64'h1);
    drain();

    // reset while F/D is held by a stall
    @(negedge clk); idle(); fetch(4'h5, 4'h0, 4'h0, 4'h2, 64'h0, 64'h0);
    @(negedge clk); idle(); fetch(4'h6, 4'h0, 4'h0, 4'h3, 64'h0, 64'h0);
    @(negedge clk); idle(); rst_n = 1'b0; #3;
    chk("rs_E_valid", E_valid, 64'h0);
    chk("rs_E_dstM", E_dstM, 64'hF);
    chk("rs_fd_srcA", rf_srcA, 64'hF);
    @(negedge clk); rst_n = 1'b1;
    drain();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      f_valid     = ($urandom_range(0, 3) != 0);
      f_icode     = 4'($urandom_range(0, 11));
      f_ifun      = 4'($urandom_range(0, 6));
      f_rA        = 4'($urandom_range(0, 15));
      f_rB        = 4'($urandom_range(0, 15));
      f_valC      = {$urandom, $urandom};
      f_valP      = {$urandom, $urandom};
      d_stall_ext = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 11) == 0);
      e_dstE = rdst(); M_dstE = rdst(); M_dstM = rdst(); W_dstE = rdst(); W_dstM = rdst();
      e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
      m_valM = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
      W_valM = {$urandom, $urandom};
      rf[$urandom_range(0, 15)] = {$urandom, $urandom};
    end
    @(negedge clk); idle();
    @(negedge clk); #3;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
